// File: rtl/fft8_seq_ctrl_if.sv
// Stream, twiddle and status signals between the 8-point FFT sequencer and its environment.
// The DUT uses the slave view; the producer/consumer/multiplier side uses the master view.
interface fft8_seq_ctrl_if #(
    parameter int WORD_SZ = 16
);
    logic               i_valid;
    logic [WORD_SZ-1:0] i_data;
    logic               o_ready;
    logic               o_valid;
    logic [WORD_SZ-1:0] o_data;
    logic               i_ready;
    logic [1:0]         o_tw_k;
    logic [WORD_SZ-1:0] o_tw_b;
    logic [WORD_SZ-1:0] i_tw_prod;
    logic               o_busy;

    modport slave (
        input  i_valid, i_data, i_ready, i_tw_prod,
        output o_ready, o_valid, o_data, o_tw_k, o_tw_b, o_busy
    );

    modport master (
        output i_valid, i_data, i_ready, i_tw_prod,
        input  o_ready, o_valid, o_data, o_tw_k, o_tw_b, o_busy
    );
endinterface

// File: rtl/fft8_seq_ctrl.sv
// 8-point radix-2 DIT FFT sequencer: bit-reversed load, 12 butterflies on one shared DFT_2,
// natural-order unload. The twiddle multiply on the B operand is done externally, combinationally.
module fft8_seq_ctrl #(
    parameter int WORD_SZ = 16
) (
    input logic          i_clk,
    input logic          i_rst,
    fft8_seq_ctrl_if.slave bus
);
    localparam int HALF_W = WORD_SZ / 2;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    state_t             state;
    logic [2:0]         cnt;
    logic [1:0]         stage;
    logic [1:0]         bfly;
    logic               ready_r;
    logic               busy_r;
    logic               valid_r;
    logic [WORD_SZ-1:0] mem [8];

    logic [2:0]         top;
    logic [2:0]         bot;
    logic [1:0]         k;
    logic [WORD_SZ-1:0] a_op;
    logic [WORD_SZ-1:0] b_op;

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // Per-half wrap-around arithmetic, same width in and out.
    function automatic logic [WORD_SZ-1:0] cadd(input logic [WORD_SZ-1:0] a, input logic [WORD_SZ-1:0] b);
        logic signed [HALF_W-1:0] re;
        logic signed [HALF_W-1:0] im;
        re = $signed(a[WORD_SZ-1:HALF_W]) + $signed(b[WORD_SZ-1:HALF_W]);
        im = $signed(a[HALF_W-1:0]) + $signed(b[HALF_W-1:0]);
        return {re, im};
    endfunction

    function automatic logic [WORD_SZ-1:0] csub(input logic [WORD_SZ-1:0] a, input logic [WORD_SZ-1:0] b);
        logic signed [HALF_W-1:0] re;
        logic signed [HALF_W-1:0] im;
        re = $signed(a[WORD_SZ-1:HALF_W]) - $signed(b[WORD_SZ-1:HALF_W]);
        im = $signed(a[HALF_W-1:0]) - $signed(b[HALF_W-1:0]);
        return {re, im};
    endfunction

    // Butterfly addressing: top/bot spaced by 1<<stage, twiddle k = pos << (2-stage).
    always_comb begin
        top = 3'd0;
        bot = 3'd0;
        k   = 2'd0;
        case (stage)
            2'd0: begin
                top = {bfly, 1'b0};
                bot = {bfly, 1'b1};
                k   = 2'd0;
            end
            2'd1: begin
                top = {bfly[1], 1'b0, bfly[0]};
                bot = {bfly[1], 1'b1, bfly[0]};
                k   = {bfly[0], 1'b0};
            end
            default: begin
                top = {1'b0, bfly};
                bot = {1'b1, bfly};
                k   = bfly;
            end
        endcase
    end

    assign a_op = mem[top];
    assign b_op = bus.i_tw_prod;

    assign bus.o_ready = ready_r;
    assign bus.o_busy  = busy_r;
    assign bus.o_valid = valid_r;
    assign bus.o_tw_k  = busy_r ? k : 2'd0;
    assign bus.o_tw_b  = busy_r ? mem[bot] : '0;
    assign bus.o_data  = valid_r ? mem[cnt] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= LOAD;
            cnt     <= 3'd0;
            stage   <= 2'd0;
            bfly    <= 2'd0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.i_valid) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            cnt     <= 3'd0;
                            state   <= COMPUTE;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    bfly <= bfly + 2'd1;
                    if (bfly == 2'd3) begin
                        if (stage == 2'd2) begin
                            stage   <= 2'd0;
                            state   <= UNLOAD;
                            busy_r  <= 1'b0;
                            valid_r <= 1'b1;
                        end else begin
                            stage <= stage + 2'd1;
                        end
                    end
                end
                UNLOAD: begin
                    if (bus.i_ready) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            cnt     <= 3'd0;
                            state   <= LOAD;
                            valid_r <= 1'b0;
                            ready_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= LOAD;
                    cnt     <= 3'd0;
                    stage   <= 2'd0;
                    bfly    <= 2'd0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Sample buffer carries no reset; every frame overwrites all eight words before use.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state == LOAD && bus.i_valid) begin
                mem[bitrev3(cnt)] <= bus.i_data;
            end else if (state == COMPUTE) begin
                mem[top] <= cadd(a_op, b_op);
                mem[bot] <= csub(a_op, b_op);
            end
        end
    end
endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Directed bench for fft8_seq_ctrl with an ideal Q7 twiddle multiplier model on the B path.
module tb_fft8_seq_ctrl;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft8_seq_ctrl_if #(.WORD_SZ(W)) bus();

    fft8_seq_ctrl #(.WORD_SZ(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // W8^k in Q7 (128 = 1.0), product truncated toward minus infinity.
    function automatic logic [15:0] twmul(input logic [1:0] kk, input logic [15:0] b);
        int ar, ai, wr, wi, pr, pim;
        ar = int'($signed(b[15:8]));
        ai = int'($signed(b[7:0]));
        case (kk)
            2'd0:    begin wr = 128; wi = 0;    end
            2'd1:    begin wr = 91;  wi = -91;  end
            2'd2:    begin wr = 0;   wi = -128; end
            default: begin wr = -91; wi = -91;  end
        endcase
        pr  = (ar * wr - ai * wi) >>> 7;
        pim = (ar * wi + ai * wr) >>> 7;
        return {pr[7:0], pim[7:0]};
    endfunction

    always_comb bus.i_tw_prod = twmul(bus.o_tw_k, bus.o_tw_b);

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_cnt = 0;
    logic [1:0] kq[$];
    int acc_cyc, first_acc, last_unl;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.o_busy) begin
            busy_cnt <= busy_cnt + 1;
            kq.push_back(bus.o_tw_k);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] din[8];
        logic [15:0] dout[8];
        bit          gaps;
        bit          stall;
    } vec_t;

    vec_t vecs[5];
    logic [1:0] kexp[12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

    task automatic load_frame(input logic [15:0] d[8], input bit gaps, input bit keep, input logic [15:0] nxt);
        int i = 0;
        int t = 0;
        bit phase = 1'b0;
        while (i < 8 && t < 300) begin
            @(negedge clk);
            t++;
            if (gaps && phase) begin
                bus.i_valid = 1'b0;
            end else begin
                bus.i_valid = 1'b1;
                bus.i_data  = d[i];
                if (bus.o_ready) begin
                    if (i == 0) first_acc = cyc + 1;
                    if (i == 7) acc_cyc = cyc + 1;
                    i++;
                end
            end
            phase = ~phase;
        end
        if (i < 8) chk("load_timeout", i, 8);
        @(negedge clk);
        bus.i_valid = keep;
        bus.i_data  = nxt;
    endtask

    task automatic unload_frame(input bit stall, input logic [15:0] exp[8], input string tag);
        int n = 0;
        int t = 0;
        int hold = 0;
        bit first = 1'b1;
        logic [15:0] held = '0;
        while (n < 8 && t < 300) begin
            @(negedge clk);
            t++;
            if (stall && n == 3 && hold < 3) begin
                bus.i_ready = 1'b0;
                if (hold == 0) begin
                    held = bus.o_data;
                end else begin
                    chk($sformatf("%s_stall_valid", tag), bus.o_valid, 1);
                    chk($sformatf("%s_stall_data", tag), bus.o_data, held);
                end
                hold++;
            end else begin
                bus.i_ready = 1'b1;
                if (bus.o_valid) begin
                    if (first) begin
                        chk($sformatf("%s_latency", tag), cyc + 1 - acc_cyc, 13);
                        chk($sformatf("%s_ready_in_unload", tag), bus.o_ready, 0);
                        first = 1'b0;
                    end
                    chk($sformatf("%s_out%0d", tag, n), bus.o_data, exp[n]);
                    last_unl = cyc + 1;
                    n++;
                end
            end
        end
        if (n < 8) chk($sformatf("%s_unload_timeout", tag), n, 8);
    endtask

    task automatic run_vec(input int v, input bit keep, input logic [15:0] nxt, input string tag);
        int busy0 = busy_cnt;
        int k0 = kq.size();
        load_frame(vecs[v].din, vecs[v].gaps, keep, nxt);
        if (vecs[v].gaps) chk($sformatf("%s_gap_span", tag), acc_cyc - first_acc, 14);
        unload_frame(vecs[v].stall, vecs[v].dout, tag);
        chk($sformatf("%s_busy_cycles", tag), busy_cnt - busy0, 12);
        if (kq.size() < k0 + 12) begin
            chk($sformatf("%s_k_count", tag), kq.size() - k0, 12);
        end else begin
            for (int j = 0; j < 12; j++)
                chk($sformatf("%s_k%0d", tag, j), kq[k0 + j], kexp[j]);
        end
    endtask

    initial begin
        int vcnt;
        int u;
        vecs[0] = '{din: '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100},
                    dout: '{16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    gaps: 1'b0, stall: 1'b0};
        vecs[1] = '{din: '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    dout: '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100},
                    gaps: 1'b0, stall: 1'b0};
        vecs[2] = '{din: '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000},
                    dout: '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    gaps: 1'b0, stall: 1'b0};
        vecs[3] = '{din: '{16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    dout: '{16'h4000, 16'h2DD2, 16'h00C0, 16'hD2D2, 16'hC000, 16'hD32E, 16'h0040, 16'h2E2E},
                    gaps: 1'b1, stall: 1'b0};
        vecs[4] = '{din: '{16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    dout: '{16'h4000, 16'h00C0, 16'hC000, 16'h0040, 16'h4000, 16'h00C0, 16'hC000, 16'h0040},
                    gaps: 1'b0, stall: 1'b1};

        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.o_ready, 1);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_data", bus.o_data, 0);
        chk("rst_tw_k", bus.o_tw_k, 0);
        chk("rst_tw_b", bus.o_tw_b, 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) run_vec(v, 1'b0, 16'h0000, $sformatf("vec%0d", v));

        // Abort a frame a few cycles into COMPUTE.
        load_frame(vecs[0].din, 1'b0, 1'b0, 16'h0000);
        repeat (4) @(negedge clk);
        chk("abort_busy_before", bus.o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_ready", bus.o_ready, 1);
        chk("abort_valid", bus.o_valid, 0);
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_valid) vcnt++;
        end
        chk("abort_no_output", vcnt, 0);
        run_vec(1, 1'b0, 16'h0000, "post_abort");

        // Back-to-back frames with i_valid held high between them.
        run_vec(0, 1'b1, vecs[1].din[0], "b2b_const");
        u = last_unl;
        run_vec(1, 1'b0, 16'h0000, "b2b_imp");
        chk("b2b_first_accept", first_acc, u + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
